// File: rtl/regfile_xfer_engine_pkg.sv
// Shared types for the register-file transfer engine: FSM state encoding
// and the Mode input values.
package regfile_xfer_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } xferState_e;

    localparam logic MODE_DUMP = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

endpackage

// File: rtl/regfile_xfer_engine_addr_counter.sv
// Loadable register-address up-counter with an equal-to-last flag; tracks
// the current register of a dump or load sweep.
module xfer_addr_counter #(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] loadVal_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] last_i,
    output logic [ADDR_W-1:0] count_o,
    output logic              atLast_o
);

    logic [ADDR_W-1:0] countQ;
    logic [ADDR_W-1:0] countD;

    // Load takes priority; the range check upstream keeps increments from wrapping.
    always_comb begin
        countD = countQ;
        if (load_i) begin
            countD = loadVal_i;
        end else if (inc_i) begin
            countD = countQ + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            countQ <= '0;
        end else begin
            countQ <= countD;
        end
    end

    assign count_o  = countQ;
    assign atLast_o = (countQ == last_i);

endmodule

// File: rtl/regfile_xfer_engine.sv
// Register-file bus master: dumps a register range onto a valid/ready stream
// or loads a range from one, while owning the register-file ports (Busy=1).
module regfile_xfer_engine
    import regfile_xfer_engine_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Mode,
    input  logic [ADDR_W-1:0] FirstAddr,
    input  logic [ADDR_W-1:0] LastAddr,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [ADDR_W:0]   WordCount,
    output logic [ADDR_W-1:0] RfAdr1,
    input  logic [DATA_W-1:0] RfDout1,
    output logic [ADDR_W-1:0] RfAwr,
    output logic [DATA_W-1:0] RfDin,
    output logic              RfWrEn,
    output logic [DATA_W-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady,
    input  logic [DATA_W-1:0] InData,
    input  logic              InValid,
    output logic              InReady
);

    xferState_e        stateQ, stateD;
    logic              dumpFirstQ, dumpFirstD;
    logic              errQ, errD;
    logic [ADDR_W:0]   wcQ, wcD;
    logic [DATA_W-1:0] outDataQ, outDataD;
    logic              outValidQ, outValidD;
    logic [ADDR_W-1:0] lastQ, lastD;

    logic              ctrLoad;
    logic              ctrInc;
    logic [ADDR_W-1:0] cur;
    logic              curAtLast;
    logic              outHs;
    logic              loadBeat;

    xfer_addr_counter #(
        .ADDR_W (ADDR_W)
    ) uCur (
        .clk_i     (Clk),
        .rst_i     (Rst),
        .load_i    (ctrLoad),
        .loadVal_i (FirstAddr),
        .inc_i     (ctrInc),
        .last_i    (lastQ),
        .count_o   (cur),
        .atLast_o  (curAtLast)
    );

    // In DUMP, cur is the address of the word held in OutData; each
    // refill reads cur+1 so the next word is ready on the handshake edge.
    always_comb begin
        stateD     = stateQ;
        dumpFirstD = 1'b0;
        errD       = errQ;
        wcD        = wcQ;
        outDataD   = outDataQ;
        outValidD  = outValidQ;
        lastD      = lastQ;
        ctrLoad    = 1'b0;
        ctrInc     = 1'b0;
        outHs      = 1'b0;
        loadBeat   = 1'b0;

        case (stateQ)
            ST_IDLE: begin
                if (Start) begin
                    ctrLoad = 1'b1;
                    lastD   = LastAddr;
                    wcD     = '0;
                    if (FirstAddr > LastAddr) begin
                        errD   = 1'b1;
                        stateD = ST_DONE;
                    end else begin
                        errD       = 1'b0;
                        stateD     = (Mode == MODE_LOAD) ? ST_LOAD : ST_DUMP;
                        dumpFirstD = (Mode == MODE_DUMP);
                    end
                end
            end
            ST_DUMP: begin
                outHs = outValidQ & OutReady;
                if (outHs) begin
                    wcD = wcQ + (ADDR_W+1)'(1);
                end
                if (dumpFirstQ || (outHs && !curAtLast)) begin
                    outDataD  = RfDout1;
                    outValidD = 1'b1;
                    ctrInc    = outHs;
                end else if (outHs) begin
                    outValidD = 1'b0;
                    stateD    = ST_DONE;
                end
            end
            ST_LOAD: begin
                loadBeat = InValid;
                if (InValid) begin
                    wcD = wcQ + (ADDR_W+1)'(1);
                    if (curAtLast) begin
                        stateD = ST_DONE;
                    end else begin
                        ctrInc = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                stateD = ST_IDLE;
            end
            default: begin
                stateD = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stateQ     <= ST_IDLE;
            dumpFirstQ <= 1'b0;
            errQ       <= 1'b0;
            wcQ        <= '0;
            outDataQ   <= '0;
            outValidQ  <= 1'b0;
            lastQ      <= '0;
        end else begin
            stateQ     <= stateD;
            dumpFirstQ <= dumpFirstD;
            errQ       <= errD;
            wcQ        <= wcD;
            outDataQ   <= outDataD;
            outValidQ  <= outValidD;
            lastQ      <= lastD;
        end
    end

    assign RfAdr1    = dumpFirstQ ? cur : (cur + ADDR_W'(1));
    assign RfAwr     = cur;
    assign RfDin     = InData;
    // R0 is hard-wired zero, and a reset edge must never coincide with a write.
    assign RfWrEn    = loadBeat & (cur != '0) & ~Rst;
    assign InReady   = (stateQ == ST_LOAD);
    assign Busy      = (stateQ == ST_DUMP) || (stateQ == ST_LOAD);
    assign Done      = (stateQ == ST_DONE);
    assign Err       = Done & errQ;
    assign WordCount = wcQ;
    assign OutData   = outDataQ;
    assign OutValid  = outValidQ;

endmodule

// File: tb/tb_regfile_xfer_engine.sv
// Self-checking bench for regfile_xfer_engine: a register-file model, a
// transaction-level reference model, and directed scenarios with literal values.
module tb_regfile_xfer_engine;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              Clk;
    logic              Rst;
    logic              Start;
    logic              Mode;
    logic [ADDR_W-1:0] FirstAddr;
    logic [ADDR_W-1:0] LastAddr;
    logic              Busy;
    logic              Done;
    logic              Err;
    logic [ADDR_W:0]   WordCount;
    logic [ADDR_W-1:0] RfAdr1;
    logic [DATA_W-1:0] RfDout1;
    logic [ADDR_W-1:0] RfAwr;
    logic [DATA_W-1:0] RfDin;
    logic              RfWrEn;
    logic [DATA_W-1:0] OutData;
    logic              OutValid;
    logic              OutReady;
    logic [DATA_W-1:0] InData;
    logic              InValid;
    logic              InReady;

    regfile_xfer_engine #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Mode      (Mode),
        .FirstAddr (FirstAddr),
        .LastAddr  (LastAddr),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err),
        .WordCount (WordCount),
        .RfAdr1    (RfAdr1),
        .RfDout1   (RfDout1),
        .RfAwr     (RfAwr),
        .RfDin     (RfDin),
        .RfWrEn    (RfWrEn),
        .OutData   (OutData),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .InData    (InData),
        .InValid   (InValid),
        .InReady   (InReady)
    );

    // Register file the engine masters: combinational read, R0 reads zero.
    logic [DATA_W-1:0] rfMem [0:31];
    assign RfDout1 = rfMem[RfAdr1];
    always @(posedge Clk) begin
        if (RfWrEn && RfAwr != 0) rfMem[RfAwr] <= RfDin;
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int compared = 0;
    int mismatched = 0;

    // Reference model state: the register contents as they should be, plus
    // what the operation in flight must produce.
    logic [DATA_W-1:0] golden [0:31];
    logic [DATA_W-1:0] expQ [$];
    logic              mActive = 1'b0;
    logic              mMode = 1'b0;
    logic              mErr = 1'b0;
    int                mLast = 0;
    int                mCount = 0;
    int                loadPtr = 0;
    int                hsCount = 0;
    int                doneCount = 0;
    logic              prevStall = 1'b0;
    logic [DATA_W-1:0] prevData = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse Start for one cycle, then arm the model for the accepted request.
    task automatic applyStimulus(input logic mode, input int first, input int last);
        @(posedge Clk); #1;
        Start     = 1'b1;
        Mode      = mode;
        FirstAddr = first[ADDR_W-1:0];
        LastAddr  = last[ADDR_W-1:0];
        @(posedge Clk); #1;
        Start   = 1'b0;
        mActive = 1'b1;
        mMode   = mode;
        mErr    = (first > last);
        mLast   = last;
        mCount  = mErr ? 0 : (last - first + 1);
        loadPtr = first;
        hsCount = 0;
        expQ.delete();
        if (!mode && !mErr) begin
            for (int a = first; a <= last; a++) expQ.push_back(golden[a]);
        end
    endtask

    task automatic waitDone(input int budget);
        int startDone;
        startDone = doneCount;
        for (int i = 0; i < budget; i++) begin
            @(posedge Clk);
            if (doneCount != startDone) break;
        end
        checkOutput("done_timeout", doneCount - startDone, 1);
    endtask

    // Cycle-by-cycle comparison against the model whenever outputs mean something.
    always @(negedge Clk) begin
        logic [DATA_W-1:0] expWord;
        if (Rst) begin
            prevStall = 1'b0;
            checkOutput("rst_wren", RfWrEn, 0);
        end else begin
            checkOutput("inready", InReady, mActive && mMode && (loadPtr <= mLast));
            if (InReady && InValid) begin
                if (loadPtr == 0) begin
                    checkOutput("wren_r0", RfWrEn, 0);
                end else begin
                    checkOutput("wren", RfWrEn, 1);
                    checkOutput("awr", RfAwr, loadPtr);
                    checkOutput("din", RfDin, InData);
                    golden[loadPtr] = InData;
                end
                loadPtr++;
                hsCount++;
            end else begin
                checkOutput("wren_idle", RfWrEn, 0);
            end
            if (prevStall) checkOutput("stall_hold", {OutValid, OutData}, {1'b1, prevData});
            if (OutValid && OutReady) begin
                if (expQ.size() > 0) expWord = expQ.pop_front();
                else expWord = 'x;
                checkOutput("odata", OutData, expWord);
                hsCount++;
            end
            prevStall = OutValid && !OutReady;
            prevData  = OutData;
            if (Done) begin
                checkOutput("done_expected", mActive, 1);
                checkOutput("done_count", WordCount, mCount);
                checkOutput("done_hs", hsCount, mCount);
                checkOutput("done_err", Err, mErr);
                checkOutput("done_busy", Busy, 0);
                mActive = 1'b0;
                doneCount++;
            end else begin
                checkOutput("busy", Busy, mActive);
                checkOutput("err_low", Err, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] got [$];
        logic              rdyPat [4];
        logic [DATA_W-1:0] stallExp [4];
        logic [DATA_W-1:0] loadVals [3];

        for (int i = 0; i < 32; i++) begin
            rfMem[i]  = (i == 0) ? '0 : (32'hA000_0000 + i);
            golden[i] = rfMem[i];
        end
        rfMem[1] = 32'h5555; rfMem[3] = 32'h11; rfMem[4] = 32'h22;
        rfMem[5] = 32'h33;   rfMem[6] = 32'h6666_6666;
        for (int i = 0; i < 32; i++) golden[i] = rfMem[i];

        Rst = 1'b1; Start = 1'b0; Mode = 1'b0; FirstAddr = '0; LastAddr = '0;
        OutReady = 1'b1; InData = '0; InValid = 1'b0;

        // Reset state.
        @(posedge Clk); @(posedge Clk);
        @(negedge Clk);
        checkOutput("reset_flags", {Busy, Done, Err, OutValid, InReady, RfWrEn}, 6'b0);
        checkOutput("reset_outdata", OutData, 0);
        checkOutput("reset_wordcount", WordCount, 0);
        checkOutput("reset_cur", RfAwr, 0);
        @(posedge Clk); #1;
        Rst = 1'b0;

        // DUMP 3..5 at full throughput.
        $display("[TB] dump 3..5");
        applyStimulus(1'b0, 3, 5);
        @(negedge Clk);
        checkOutput("t1_first_valid_late", OutValid, 0);
        @(negedge Clk);
        checkOutput("t1_w0", {OutValid, OutData}, {1'b1, 32'h11});
        @(negedge Clk);
        checkOutput("t1_w1", {OutValid, OutData}, {1'b1, 32'h22});
        @(negedge Clk);
        checkOutput("t1_w2", {OutValid, OutData}, {1'b1, 32'h33});
        @(negedge Clk);
        checkOutput("t1_done", {Done, Err, OutValid}, 3'b100);
        checkOutput("t1_wordcount", WordCount, 3);

        // DUMP 0..1 with back-pressure.
        $display("[TB] dump 0..1 stalled");
        rdyPat   = '{1'b1, 1'b0, 1'b0, 1'b1};
        stallExp = '{32'h0, 32'h5555, 32'h5555, 32'h5555};
        applyStimulus(1'b0, 0, 1);
        @(negedge Clk);
        for (int k = 0; k < 4; k++) begin
            @(posedge Clk); #1;
            OutReady = rdyPat[k];
            @(negedge Clk);
            checkOutput("t2_word", {OutValid, OutData}, {1'b1, stallExp[k]});
        end
        @(negedge Clk);
        checkOutput("t2_done", Done, 1);
        checkOutput("t2_wordcount", WordCount, 2);
        @(posedge Clk); #1;
        OutReady = 1'b1;

        // LOAD 0..2: the R0 word is consumed but never written.
        $display("[TB] load 0..2");
        loadVals = '{32'hAAAA, 32'hBBBB, 32'hCCCC};
        applyStimulus(1'b1, 0, 2);
        for (int k = 0; k < 3; k++) begin
            InData  = loadVals[k];
            InValid = 1'b1;
            @(negedge Clk);
            checkOutput("t3_wren", RfWrEn, (k != 0));
            if (k != 0) checkOutput("t3_awr", RfAwr, k);
            @(posedge Clk); #1;
        end
        InValid = 1'b0;
        @(negedge Clk);
        checkOutput("t3_done", {Done, Err}, 2'b10);
        checkOutput("t3_wordcount", WordCount, 3);
        checkOutput("t3_rf", {rfMem[0], rfMem[1], rfMem[2]}, {32'h0, 32'hBBBB, 32'hCCCC});

        applyStimulus(1'b0, 0, 2);
        got.delete();
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (OutValid && OutReady) got.push_back(OutData);
            if (Done) break;
        end
        checkOutput("t3_dump_len", got.size(), 3);
        if (got.size() == 3) checkOutput("t3_dump_data", {got[0], got[1], got[2]}, {32'h0, 32'hBBBB, 32'hCCCC});

        // Empty range 9..4.
        $display("[TB] empty range");
        applyStimulus(1'b0, 9, 4);
        @(negedge Clk);
        checkOutput("t4_done_err", {Done, Err, Busy, OutValid, RfWrEn}, 5'b11000);
        checkOutput("t4_wordcount", WordCount, 0);
        @(negedge Clk);
        checkOutput("t4_after", {Done, Busy, OutValid}, 3'b000);

        // LOAD 1..31 aborted by reset after five words.
        $display("[TB] load aborted by reset");
        applyStimulus(1'b1, 1, 31);
        for (int k = 0; k < 5; k++) begin
            InData  = 32'h101 + k;
            InValid = 1'b1;
            @(posedge Clk); #1;
        end
        Rst    = 1'b1;
        InData = 32'h106;
        @(negedge Clk);
        checkOutput("t5_rst_cycle_wren", RfWrEn, 0);
        @(posedge Clk); #1;
        Rst = 1'b0; InValid = 1'b0;
        mActive = 1'b0; expQ.delete();
        @(negedge Clk);
        checkOutput("t5_idle", {Busy, InReady, OutValid, Done}, 4'b0000);
        checkOutput("t5_wordcount", WordCount, 0);
        checkOutput("t5_r1_r5", {rfMem[1], rfMem[2], rfMem[3], rfMem[4], rfMem[5]},
                    {32'h101, 32'h102, 32'h103, 32'h104, 32'h105});
        checkOutput("t5_r6", rfMem[6], 32'h6666_6666);

        // Start pulses while in DUMP and in DONE are ignored.
        $display("[TB] start ignored while busy");
        applyStimulus(1'b0, 3, 5);
        Start = 1'b1; Mode = 1'b1; FirstAddr = 5'd0; LastAddr = 5'd0;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Start = 1'b1;
        @(negedge Clk);
        checkOutput("t6_done", Done, 1);
        checkOutput("t6_wordcount", WordCount, 3);
        @(posedge Clk); #1;
        Start = 1'b0;
        @(negedge Clk);
        checkOutput("t6_idle", {Busy, Done, InReady, OutValid}, 4'b0000);
        @(negedge Clk);
        checkOutput("t6_still_idle", {Busy, Done}, 2'b00);

        // Full range dump through the model only.
        $display("[TB] dump 0..31");
        applyStimulus(1'b0, 0, 31);
        waitDone(100);

        repeat (2) @(posedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
